// File: rtl/vin_frequency_pkg.sv
// Shared state encoding, limits and the saturating scale helper for vin_frequency.
package vin_frequency_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam logic [31:0] FREQ_MAX = 32'h7FFF_FFFF;

  // Wide product so a saturated edge count times any 32-bit scale cannot wrap.
  function automatic logic [31:0] sat_scale(input logic [32:0] count, input logic [31:0] scale);
    logic [64:0] prod;
    prod = {32'd0, count} * {33'd0, scale};
    if (prod > {33'd0, FREQ_MAX}) return FREQ_MAX;
    return prod[31:0];
  endfunction

endpackage

// File: rtl/vin_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input followed by a rising-edge detector.
module vin_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync_out,
  output logic rise
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign sync_out = chain[SYNC_STAGES-1];
  assign rise     = sync_out & ~prev;

endmodule

// File: rtl/vin_frequency.sv
// Gated rising-edge counter that publishes a scaled, saturated frequency word once per window.
// Optional direction input enabled by defining VIN_FREQUENCY_DIR_EN.
module vin_frequency
  import vin_frequency_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = 5000000,
  parameter int unsigned FREQ_SCALE  = 10,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               SIGNAL,
`ifdef VIN_FREQUENCY_DIR_EN
  input  logic               DIR,
`endif
  input  logic               disabled,
  output logic signed [31:0] frequency,
  output logic               valid
);

  localparam logic [31:0] GATE_LAST   = 32'(GATE_CYCLES - 1);
  localparam logic [31:0] SETTLE_LAST = 32'(SYNC_STAGES);

  state_t             state, state_nxt;
  logic [31:0]        gate_cnt;
  logic [31:0]        edge_cnt;
  logic               sig_rise;
  logic               sig_sync_unused;
  logic               dir_neg;
  logic               settle_done;
  logic               window_end;
  logic [32:0]        total;
  logic [31:0]        mag;
  logic signed [31:0] next_freq;

  vin_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sig (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (SIGNAL),
    .sync_out (sig_sync_unused),
    .rise     (sig_rise)
  );

`ifdef VIN_FREQUENCY_DIR_EN
  logic dir_sync;
  logic dir_rise_unused;

  vin_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_dir (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (DIR),
    .sync_out (dir_sync),
    .rise     (dir_rise_unused)
  );

  assign dir_neg = ~dir_sync;
`else
  assign dir_neg = 1'b0;
`endif

  // The gate counter doubles as the settle timer; it is always 0 on entry to SETTLE.
  assign settle_done = (state == SETTLE) && (gate_cnt == SETTLE_LAST);
  assign window_end  = (state == MEASURE) && (gate_cnt == GATE_LAST);
  assign total       = {1'b0, edge_cnt} + {32'd0, sig_rise};
  assign mag         = sat_scale(total, 32'(FREQ_SCALE));
  assign next_freq   = dir_neg ? -$signed(mag) : $signed(mag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SETTLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (disabled) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = SETTLE;
        SETTLE:  if (settle_done) state_nxt = MEASURE;
        MEASURE: state_nxt = MEASURE;
        default: state_nxt = SETTLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt  <= '0;
      edge_cnt  <= '0;
      frequency <= '0;
      valid     <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (disabled) begin
        gate_cnt  <= '0;
        edge_cnt  <= '0;
        frequency <= '0;
      end else begin
        case (state)
          SETTLE: begin
            gate_cnt <= settle_done ? '0 : gate_cnt + 32'd1;
            edge_cnt <= '0;
          end
          MEASURE: begin
            if (window_end) begin
              gate_cnt  <= '0;
              edge_cnt  <= '0;
              frequency <= next_freq;
              valid     <= 1'b1;
            end else begin
              gate_cnt <= gate_cnt + 32'd1;
              if (sig_rise && (edge_cnt != '1)) edge_cnt <= edge_cnt + 32'd1;
            end
          end
          default: begin
            gate_cnt <= '0;
            edge_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vin_frequency.sv
// Bench for vin_frequency: per-cycle scoreboard from logged input samples, vector table,
// hand-written corner sequences and a randomized phase. Honors VIN_FREQUENCY_DIR_EN.
module tb_vin_frequency;

  localparam int     GATE    = 1000;
  localparam int     SYNC    = 2;
  localparam longint SCALE_A = 50;
  localparam longint SCALE_B = 64'h1000_0000;
  localparam longint FMAX    = 64'h7FFF_FFFF;
  localparam int     LOG_N   = 60000;
`ifdef VIN_FREQUENCY_DIR_EN
  localparam bit     DIR_EN  = 1'b1;
`else
  localparam bit     DIR_EN  = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sig = 1'b0;
  logic dir = 1'b1;
  logic dis = 1'b0;
  logic signed [31:0] freq_a, freq_b;
  logic valid_a, valid_b;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic s_log [LOG_N];
  logic d_log [LOG_N];
  int meas_start = 1 << 30;
  longint m_freq_a = 0, m_freq_b = 0;
  logic m_valid = 1'b0;

  // signal generator: 0 square wave, 1 random, 2 constant, 3 aligned-edge pattern
  int   gen_mode  = 2;
  int   half      = 50;
  logic sig_const = 1'b1;
  int   pat_s = 0, pat_w = 0;

  always #5 clk = ~clk;

  vin_frequency #(.GATE_CYCLES(GATE), .FREQ_SCALE(50), .SYNC_STAGES(SYNC)) dut_a (
    .clk(clk), .rst_n(rst_n), .SIGNAL(sig),
`ifdef VIN_FREQUENCY_DIR_EN
    .DIR(dir),
`endif
    .disabled(dis), .frequency(freq_a), .valid(valid_a));

  vin_frequency #(.GATE_CYCLES(GATE), .FREQ_SCALE(32'h1000_0000), .SYNC_STAGES(SYNC)) dut_b (
    .clk(clk), .rst_n(rst_n), .SIGNAL(sig),
`ifdef VIN_FREQUENCY_DIR_EN
    .DIR(dir),
`endif
    .disabled(dis), .frequency(freq_b), .valid(valid_b));

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s at cycle %0d: timed out waiting for valid", name, cyc);
  endtask

  // Rising edges of the sampled input whose synchronized copy lands inside the window ending at n.
  function automatic longint window_count(int n);
    longint c = 0;
    for (int m = n - GATE + 1; m <= n; m++)
      if (s_log[m-SYNC] && !s_log[m-SYNC-1]) c++;
    return c;
  endfunction

  function automatic longint publish(longint cnt, longint scale, bit neg);
    longint mag = cnt * scale;
    if (mag > FMAX) mag = FMAX;
    return neg ? -mag : mag;
  endfunction

  function automatic logic pattern(int t);
    if (t >= pat_w - SYNC) return 1'b1;
    for (int j = 0; j < 9; j++)
      if (t >= pat_s + 50 + 100*j && t <= pat_s + 59 + 100*j) return 1'b1;
    return 1'b0;
  endfunction

  // Input generator: the only writer of sig.
  initial begin
    int ph = 0;
    int hold = 0;
    forever begin
      @(negedge clk);
      case (gen_mode)
        0: begin
          ph++;
          if (ph >= half) begin ph = 0; sig = ~sig; end
        end
        1: begin
          if (hold == 0) begin
            sig  = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 150);
          end else hold--;
        end
        3: sig = pattern(cyc + 1);
        default: sig = sig_const;
      endcase
    end
  end

  // Scoreboard: every cycle, both instances against the window model.
  initial begin
    logic rst_at, dis_at;
    longint cnt;
    bit neg;
    forever begin
      @(posedge clk);
      cyc++;
      s_log[cyc] = sig;
      d_log[cyc] = dir;
      rst_at = rst_n;
      dis_at = dis;
      #1;
      if (!rst_at) begin
        m_freq_a = 0; m_freq_b = 0; m_valid = 1'b0;
        meas_start = cyc + SYNC + 2;
      end else if (dis_at) begin
        m_freq_a = 0; m_freq_b = 0; m_valid = 1'b0;
        meas_start = cyc + SYNC + 3;
      end else if (cyc >= meas_start && (cyc - meas_start) % GATE == GATE - 1) begin
        cnt = window_count(cyc);
        neg = DIR_EN && !d_log[cyc-SYNC];
        m_freq_a = publish(cnt, SCALE_A, neg);
        m_freq_b = publish(cnt, SCALE_B, neg);
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
      check("sb_valid_a", longint'(valid_a), longint'(m_valid));
      check("sb_valid_b", longint'(valid_b), longint'(m_valid));
      check("sb_freq_a", longint'(freq_a), m_freq_a);
      check("sb_freq_b", longint'(freq_b), m_freq_b);
    end
  end

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #2;
      if (valid_a) begin ok = 1'b1; return; end
    end
  endtask

  task automatic wait_cyc(input int target);
    for (int i = 0; i < 5000 && cyc < target; i++) @(negedge clk);
  endtask

  typedef struct {
    int     half;
    logic   dir;
    longint exp_a;
    longint exp_b;
  } vec_t;

  initial begin
    vec_t vecs[7];
    bit ok;
    int l_edge, v_edge;
    longint ea, eb;

    vecs = '{
      '{50,  1'b0, 500,  FMAX},
      '{50,  1'b1, 500,  FMAX},
      '{25,  1'b1, 1000, FMAX},
      '{100, 1'b0, 250,  64'h5000_0000},
      '{125, 1'b1, 200,  64'h4000_0000},
      '{20,  1'b0, 1250, FMAX},
      '{500, 1'b1, 50,   64'h1000_0000}
    };

    // reset state, then input static high through reset release
    gen_mode = 2; sig_const = 1'b1;
    #22;
    check("reset_freq", longint'(freq_a), 0);
    check("reset_valid", longint'(valid_a), 0);
    @(negedge clk); rst_n = 1'b1; l_edge = cyc;
    wait_valid(1100, ok);
    if (!ok) fail_now("static_first");
    else begin
      check("first_window_latency", cyc, l_edge + SYNC + 2 + GATE - 1);
      check("static_high_freq", longint'(freq_a), 0);
    end
    for (int k = 0; k < 2; k++) begin
      wait_valid(1100, ok);
      if (!ok) fail_now("static_next");
      else check("static_high_freq", longint'(freq_a), 0);
    end

    // square wave period 100 after reset
    @(negedge clk); rst_n = 1'b0; gen_mode = 0; half = 50; dir = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1; l_edge = cyc;
    wait_valid(1100, ok);
    if (!ok) fail_now("square_first");
    else begin
      check("square_latency", cyc, l_edge + SYNC + 2 + GATE - 1);
      check("square_freq", longint'(freq_a), 500);
    end
    v_edge = cyc;
    wait_valid(1100, ok);
    if (!ok) fail_now("square_second");
    else begin
      check("square_period", cyc - v_edge, GATE);
      check("square_freq2", longint'(freq_a), 500);
    end

    // disable at cycle 450 of a window, then re-enable
    v_edge = cyc;
    wait_cyc(v_edge + 450);
    dis = 1'b1;
    @(posedge clk); #2;
    check("disable_freq", longint'(freq_a), 0);
    check("disable_valid", longint'(valid_a), 0);
    repeat (10) @(negedge clk);
    dis = 1'b0; l_edge = cyc;
    wait_valid(1200, ok);
    if (!ok) fail_now("reenable");
    else begin
      check("reenable_latency", cyc, l_edge + 1 + SYNC + 1 + GATE);
      check("reenable_freq", longint'(freq_a), 500);
    end

    // async reset mid-window
    repeat (300) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_freq_a", longint'(freq_a), 0);
    check("async_rst_freq_b", longint'(freq_b), 0);
    check("async_rst_valid", longint'(valid_a), 0);
    @(negedge clk); rst_n = 1'b1;

    // edge landing on the last gate cycle plus nine earlier edges
    gen_mode = 2; sig_const = 1'b0;
    @(negedge clk); dis = 1'b1;
    repeat (10) @(negedge clk);
    pat_s = cyc + 5; pat_w = pat_s + GATE - 1;
    gen_mode = 3;
    dis = 1'b0;
    wait_valid(1200, ok);
    if (!ok) fail_now("aligned_first");
    else begin
      check("aligned_edge_cycle", cyc, pat_w);
      check("aligned_freq", longint'(freq_a), 500);
    end
    wait_valid(1100, ok);
    if (!ok) fail_now("aligned_next");
    else check("aligned_next_freq", longint'(freq_a), 0);

    // vector table of periodic inputs
    gen_mode = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      dis = 1'b1; half = vecs[i].half; dir = vecs[i].dir;
      repeat (5) @(negedge clk);
      dis = 1'b0;
      wait_valid(1100, ok);
      if (!ok) fail_now("table");
      else begin
        ea = (DIR_EN && !vecs[i].dir) ? -vecs[i].exp_a : vecs[i].exp_a;
        eb = (DIR_EN && !vecs[i].dir) ? -vecs[i].exp_b : vecs[i].exp_b;
        check("table_freq_a", longint'(freq_a), ea);
        check("table_freq_b", longint'(freq_b), eb);
      end
    end

    // randomized input, direction and disable activity
    gen_mode = 1;
    for (int i = 0; i < 12000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 2999) == 0) dis = ~dis;
      if ($urandom_range(0, 199) == 0) dir = ~dir;
    end
    dis = 1'b0;
    repeat (1100) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
